// File: rtl/proc_csr_io_if.sv
// CSR-mapped I/O bundle: W-stage CSR read/write ports plus the per-channel
// output and input val/rdy streams.
interface proc_csr_io_if #(
  parameter int unsigned p_nbits   = 32,
  parameter int unsigned p_num_in  = 3,
  parameter int unsigned p_num_out = 3
);
  logic                           csrw_en;
  logic [3:0]                     csrw_idx;
  logic [p_nbits-1:0]             csrw_data;
  logic                           csrw_rdy;
  logic                           csrr_en;
  logic [3:0]                     csrr_idx;
  logic [p_nbits-1:0]             csrr_data;
  logic                           csrr_rdy;
  logic [p_num_out-1:0]           out_val;
  logic [p_num_out*p_nbits-1:0]   out_data;
  logic [p_num_out-1:0]           out_rdy;
  logic [p_num_in-1:0]            in_val;
  logic [p_num_in*p_nbits-1:0]    in_data;
  logic [p_num_in-1:0]            in_rdy;
  logic                           err;

  modport master (
    output csrw_en, csrw_idx, csrw_data, csrr_en, csrr_idx, out_rdy, in_val, in_data,
    input  csrw_rdy, csrr_data, csrr_rdy, out_val, out_data, in_rdy, err
  );

  modport slave (
    input  csrw_en, csrw_idx, csrw_data, csrr_en, csrr_idx, out_rdy, in_val, in_data,
    output csrw_rdy, csrr_data, csrr_rdy, out_val, out_data, in_rdy, err
  );
endinterface

// File: rtl/proc_csr_io.sv
// Parametrised CSR-mapped I/O unit: CSR writes feed per-channel output FIFOs,
// CSR reads consume input streams combinationally or return a status word.
module proc_csr_io #(
  parameter int unsigned p_nbits   = 32,
  parameter int unsigned p_num_in  = 3,
  parameter int unsigned p_num_out = 3,
  parameter int unsigned p_depth   = 4
) (
  input  logic          clk,
  input  logic          rst,
  proc_csr_io_if.slave  bus
);

  localparam int unsigned PtrW = $clog2(p_depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [3:0] NumIn     = 4'(p_num_in);
  localparam logic [3:0] NumOut    = 4'(p_num_out);
  localparam logic [3:0] StatusIdx = 4'hF;
  localparam logic [CntW-1:0] CntFull = CntW'(p_depth);

  logic [p_nbits-1:0] mem_q [p_num_out][p_depth];
  logic [PtrW-1:0]    head_q [p_num_out];
  logic [PtrW-1:0]    head_d [p_num_out];
  logic [PtrW-1:0]    tail_q [p_num_out];
  logic [PtrW-1:0]    tail_d [p_num_out];
  logic [CntW-1:0]    cnt_q  [p_num_out];
  logic [CntW-1:0]    cnt_d  [p_num_out];

  logic [p_num_out-1:0] full, enq, deq;
  logic                 wr_oor, rd_oor;
  logic                 err_q, err_d;

  always_comb begin
    for (int k = 0; k < p_num_out; k++) begin
      full[k]        = (cnt_q[k] == CntFull);
      deq[k]         = (cnt_q[k] != '0) && bus.out_rdy[k];
      bus.out_val[k] = (cnt_q[k] != '0);
      bus.out_data[k*p_nbits +: p_nbits] = mem_q[k][head_q[k]];
    end
  end

  // Ready depends only on fullness, never on out_rdy, to avoid a comb path
  // from consumer ready back into the W-stage stall.
  always_comb begin
    wr_oor       = (bus.csrw_idx >= NumOut);
    bus.csrw_rdy = wr_oor;
    enq          = '0;
    for (int k = 0; k < p_num_out; k++) begin
      if (bus.csrw_idx == 4'(k)) begin
        bus.csrw_rdy = !full[k];
        enq[k]       = bus.csrw_en && !full[k];
      end
    end
  end

  always_comb begin
    bus.csrr_rdy  = 1'b1;
    bus.csrr_data = '0;
    bus.in_rdy    = '0;
    rd_oor        = 1'b0;
    if (bus.csrr_idx == StatusIdx) begin
      if (bus.csrr_en) begin
        bus.csrr_data[p_num_in-1:0]      = bus.in_val;
        bus.csrr_data[16 +: p_num_out]   = full;
      end
    end else if (bus.csrr_idx < NumIn) begin
      for (int k = 0; k < p_num_in; k++) begin
        if (bus.csrr_idx == 4'(k)) begin
          bus.csrr_rdy  = bus.in_val[k];
          bus.in_rdy[k] = bus.csrr_en && bus.in_val[k];
          if (bus.csrr_en) begin
            bus.csrr_data = bus.in_data[k*p_nbits +: p_nbits];
          end
        end
      end
    end else begin
      rd_oor = 1'b1;
    end
  end

  always_comb begin
    err_d = err_q | (bus.csrw_en & wr_oor) | (bus.csrr_en & rd_oor);
    for (int k = 0; k < p_num_out; k++) begin
      head_d[k] = head_q[k] + PtrW'(deq[k]);
      tail_d[k] = tail_q[k] + PtrW'(enq[k]);
      case ({enq[k], deq[k]})
        2'b10:   cnt_d[k] = cnt_q[k] + CntW'(1);
        2'b01:   cnt_d[k] = cnt_q[k] - CntW'(1);
        default: cnt_d[k] = cnt_q[k];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
      for (int k = 0; k < p_num_out; k++) begin
        head_q[k] <= '0;
        tail_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      err_q <= err_d;
      for (int k = 0; k < p_num_out; k++) begin
        head_q[k] <= head_d[k];
        tail_q[k] <= tail_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    for (int k = 0; k < p_num_out; k++) begin
      if (enq[k]) begin
        mem_q[k][tail_q[k]] <= bus.csrw_data;
      end
    end
  end

  assign bus.err = err_q;

endmodule

// File: tb/tb_proc_csr_io.sv
// Directed bench for proc_csr_io with the default 3-in/3-out, depth-4 setup.
module tb_proc_csr_io;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  proc_csr_io_if #(.p_nbits(32), .p_num_in(3), .p_num_out(3)) bus ();

  proc_csr_io #(.p_nbits(32), .p_num_in(3), .p_num_out(3), .p_depth(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.csrw_en   = 1'b0;
    bus.csrw_idx  = 4'h0;
    bus.csrw_data = '0;
    bus.csrr_en   = 1'b0;
    bus.csrr_idx  = 4'h0;
    bus.out_rdy   = '0;
    bus.in_val    = '0;
    bus.in_data   = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.out_val !== 3'b000) begin
      n_fail++; $display("FAIL reset_out_val: got %b expected %b", bus.out_val, 3'b000);
    end
    n_checks++;
    if (bus.in_rdy !== 3'b000) begin
      n_fail++; $display("FAIL reset_in_rdy: got %b expected %b", bus.in_rdy, 3'b000);
    end
    n_checks++;
    if (bus.err !== 1'b0) begin
      n_fail++; $display("FAIL reset_err: got %b expected %b", bus.err, 1'b0);
    end
    bus.csrr_en  = 1'b1;
    bus.csrr_idx = 4'hF;
    bus.in_val   = 3'b010;
    #1;
    n_checks++;
    if (bus.csrr_data !== 32'h0000_0002 || bus.csrr_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_status: got data=%h rdy=%b expected data=%h rdy=1",
               bus.csrr_data, bus.csrr_rdy, 32'h0000_0002);
    end
    n_checks++;
    if (bus.in_rdy !== 3'b000) begin
      n_fail++; $display("FAIL status_in_rdy: got %b expected %b", bus.in_rdy, 3'b000);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_single_write();
    bus.csrw_en   = 1'b1;
    bus.csrw_idx  = 4'd1;
    bus.csrw_data = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if (bus.csrw_rdy !== 1'b1) begin
      n_fail++; $display("FAIL write_rdy: got %b expected 1", bus.csrw_rdy);
    end
    n_checks++;
    if (bus.out_val !== 3'b000) begin
      n_fail++; $display("FAIL write_no_bypass: got %b expected %b", bus.out_val, 3'b000);
    end
    tick();
    bus.csrw_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (bus.out_val !== 3'b010 || bus.out_data[63:32] !== 32'hDEAD_BEEF) begin
        n_fail++;
        $display("FAIL write_held[%0d]: got val=%b data=%h expected val=010 data=deadbeef",
                 i, bus.out_val, bus.out_data[63:32]);
      end
      tick();
    end
    bus.out_rdy = 3'b010;
    tick();
    bus.out_rdy = 3'b000;
    #1;
    n_checks++;
    if (bus.out_val !== 3'b000) begin
      n_fail++; $display("FAIL write_dequeued: got %b expected %b", bus.out_val, 3'b000);
    end
  endtask

  task automatic test_fill_full();
    logic [31:0] exp_q [$];
    for (int i = 1; i <= 4; i++) begin
      bus.csrw_en   = 1'b1;
      bus.csrw_idx  = 4'd0;
      bus.csrw_data = 32'(i);
      #1;
      n_checks++;
      if (bus.csrw_rdy !== 1'b1) begin
        n_fail++; $display("FAIL fill_rdy[%0d]: got %b expected 1", i, bus.csrw_rdy);
      end
      tick();
    end
    // Fifth write while ch0 full and being drained; status read alongside.
    bus.csrw_data = 32'd5;
    bus.out_rdy   = 3'b001;
    bus.csrr_en   = 1'b1;
    bus.csrr_idx  = 4'hF;
    #1;
    n_checks++;
    if (bus.csrw_rdy !== 1'b0) begin
      n_fail++; $display("FAIL full_rdy: got %b expected 0", bus.csrw_rdy);
    end
    n_checks++;
    if (bus.csrr_data !== 32'h0001_0000) begin
      n_fail++; $display("FAIL full_status: got %h expected %h", bus.csrr_data, 32'h0001_0000);
    end
    n_checks++;
    if (bus.out_data[31:0] !== 32'd1) begin
      n_fail++; $display("FAIL drain_first: got %h expected %h", bus.out_data[31:0], 32'd1);
    end
    tick();
    bus.csrr_en = 1'b0;
    bus.out_rdy = 3'b000;
    #1;
    n_checks++;
    if (bus.csrw_rdy !== 1'b1) begin
      n_fail++; $display("FAIL refill_rdy: got %b expected 1", bus.csrw_rdy);
    end
    tick();
    bus.csrw_en = 1'b0;
    exp_q = '{32'd2, 32'd3, 32'd4, 32'd5};
    bus.out_rdy = 3'b001;
    foreach (exp_q[i]) begin
      #1;
      n_checks++;
      if (bus.out_val[0] !== 1'b1 || bus.out_data[31:0] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL drain_order[%0d]: got val=%b data=%h expected val=1 data=%h",
                 i, bus.out_val[0], bus.out_data[31:0], exp_q[i]);
      end
      tick();
    end
    bus.out_rdy = 3'b000;
    #1;
    n_checks++;
    if (bus.out_val[0] !== 1'b0) begin
      n_fail++; $display("FAIL drain_empty: got %b expected 0", bus.out_val[0]);
    end
  endtask

  task automatic test_concurrent();
    logic [31:0] exp_q [$];
    bus.csrw_en  = 1'b1;
    bus.csrw_idx = 4'd2;
    bus.csrw_data = 32'd7;
    tick();
    bus.csrw_data = 32'd8;
    tick();
    bus.csrw_data = 32'd9;
    bus.out_rdy   = 3'b100;
    #1;
    n_checks++;
    if (bus.csrw_rdy !== 1'b1 || bus.out_data[95:64] !== 32'd7) begin
      n_fail++;
      $display("FAIL concurrent_enq_deq: got rdy=%b head=%h expected rdy=1 head=7",
               bus.csrw_rdy, bus.out_data[95:64]);
    end
    tick();
    bus.csrw_en = 1'b0;
    exp_q = '{32'd8, 32'd9};
    foreach (exp_q[i]) begin
      #1;
      n_checks++;
      if (bus.out_val[2] !== 1'b1 || bus.out_data[95:64] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL concurrent_order[%0d]: got val=%b data=%h expected val=1 data=%h",
                 i, bus.out_val[2], bus.out_data[95:64], exp_q[i]);
      end
      tick();
    end
    bus.out_rdy = 3'b000;
    #1;
    n_checks++;
    if (bus.out_val[2] !== 1'b0) begin
      n_fail++; $display("FAIL concurrent_count: got val=%b expected 0", bus.out_val[2]);
    end
  endtask

  task automatic test_input_stall();
    bus.csrr_en  = 1'b1;
    bus.csrr_idx = 4'd0;
    bus.in_val   = 3'b000;
    bus.in_data  = {32'hCCCC_0002, 32'hBBBB_0001, 32'h0000_1234};
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if (bus.csrr_rdy !== 1'b0 || bus.in_rdy !== 3'b000) begin
        n_fail++;
        $display("FAIL input_stall[%0d]: got rdy=%b in_rdy=%b expected rdy=0 in_rdy=000",
                 i, bus.csrr_rdy, bus.in_rdy);
      end
      tick();
    end
    bus.in_val = 3'b001;
    #1;
    n_checks++;
    if (bus.csrr_rdy !== 1'b1 || bus.csrr_data !== 32'h0000_1234 || bus.in_rdy !== 3'b001) begin
      n_fail++;
      $display("FAIL input_read: got rdy=%b data=%h in_rdy=%b expected rdy=1 data=1234 in_rdy=001",
               bus.csrr_rdy, bus.csrr_data, bus.in_rdy);
    end
    tick();
    bus.csrr_en = 1'b0;
    #1;
    n_checks++;
    if (bus.in_rdy !== 3'b000 || bus.csrr_data !== 32'h0) begin
      n_fail++;
      $display("FAIL input_idle: got in_rdy=%b data=%h expected in_rdy=000 data=0",
               bus.in_rdy, bus.csrr_data);
    end
    bus.csrr_en  = 1'b1;
    bus.csrr_idx = 4'd2;
    bus.in_val   = 3'b101;
    #1;
    n_checks++;
    if (bus.csrr_data !== 32'hCCCC_0002 || bus.in_rdy !== 3'b100) begin
      n_fail++;
      $display("FAIL input_ch2: got data=%h in_rdy=%b expected data=cccc0002 in_rdy=100",
               bus.csrr_data, bus.in_rdy);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_oor_and_reset();
    bus.csrw_en   = 1'b1;
    bus.csrw_idx  = 4'd7;
    bus.csrw_data = 32'hFFFF_FFFF;
    #1;
    n_checks++;
    if (bus.csrw_rdy !== 1'b1 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_write_rdy: got rdy=%b err=%b expected rdy=1 err=0", bus.csrw_rdy, bus.err);
    end
    tick();
    bus.csrw_en = 1'b0;
    #1;
    n_checks++;
    if (bus.out_val !== 3'b000 || bus.err !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_write_err: got val=%b err=%b expected val=000 err=1", bus.out_val, bus.err);
    end
    bus.csrr_en  = 1'b1;
    bus.csrr_idx = 4'd5;
    #1;
    n_checks++;
    if (bus.csrr_rdy !== 1'b1 || bus.csrr_data !== 32'h0) begin
      n_fail++;
      $display("FAIL oor_read: got rdy=%b data=%h expected rdy=1 data=0", bus.csrr_rdy, bus.csrr_data);
    end
    tick();
    bus.csrr_en  = 1'b0;
    bus.csrw_en  = 1'b1;
    bus.csrw_idx = 4'd1;
    for (int i = 0; i < 3; i++) begin
      bus.csrw_data = 32'(100 + i);
      tick();
    end
    bus.csrw_en = 1'b0;
    #1;
    n_checks++;
    if (bus.out_val !== 3'b010 || bus.err !== 1'b1) begin
      n_fail++;
      $display("FAIL preload: got val=%b err=%b expected val=010 err=1", bus.out_val, bus.err);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.out_val !== 3'b000 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_reset: got val=%b err=%b expected val=000 err=0", bus.out_val, bus.err);
    end
    bus.csrw_en   = 1'b1;
    bus.csrw_data = 32'hA5A5_0000;
    tick();
    bus.csrw_en = 1'b0;
    #1;
    n_checks++;
    if (bus.out_val !== 3'b010 || bus.out_data[63:32] !== 32'hA5A5_0000) begin
      n_fail++;
      $display("FAIL post_reset_write: got val=%b data=%h expected val=010 data=a5a50000",
               bus.out_val, bus.out_data[63:32]);
    end
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_single_write();
    test_fill_full();
    test_concurrent();
    test_input_stall();
    test_oor_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/proc_csr_io.md
Name: proc_csr_io

Overview:
- Parametrised CSR-mapped I/O unit for the TinyRV1 processor.
- Replaces the fixed three-channel in/out wiring with p_num_in input and p_num_out output channels.
- Each output channel carries a val/rdy stream buffered by a p_depth-entry FIFO.
- Inputs are consumed through val/rdy handshakes. The W stage stalls on csrw_rdy/csrr_rdy.

Parameters:
- p_nbits, 32, data width of every channel.
- p_num_in, 3, number of input channels (1..15).
- p_num_out, 3, number of output channels (1..15).
- p_depth, 4, entries per output FIFO (power of 2, >=2).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- csrw_en  input  1  W-stage CSR write request
- csrw_idx  input  4  output channel index
- csrw_data  input  p_nbits  write data
- csrw_rdy  output  1  write accepted this cycle
- csrr_en  input  1  W-stage CSR read request
- csrr_idx  input  4  input channel index; 4'hF = status
- csrr_data  output  p_nbits  read data
- csrr_rdy  output  1  read completes this cycle
- out_val  output  p_num_out  per-channel output valid
- out_data  output  p_num_out*p_nbits  channel k at bits [k*p_nbits +: p_nbits]
- out_rdy  input  p_num_out  per-channel consumer ready
- in_val  input  p_num_in  per-channel input valid
- in_data  input  p_num_in*p_nbits  channel k at bits [k*p_nbits +: p_nbits]
- in_rdy  output  p_num_in  per-channel input consumed
- err  output  1  sticky out-of-range access flag

Behaviour:
- Reset: one clock, synchronous, active-high. Reset is applied on the rising edge with rst=1.
  - Reset empties all FIFOs (pointers and counts = 0) and clears err to 0.
  - After reset: out_val=0, in_rdy=0. csrw_rdy and csrr_rdy follow the combinational rules below.
  - A reset asserted mid-operation discards all queued data; no partial dequeue survives.
- Output FIFO k:
  - Circular buffer of p_depth entries with a count of $clog2(p_depth)+1 bits. Pointers wrap modulo p_depth.
  - Enqueue: csrw_en && csrw_idx==k && csrw_rdy. Data appears at out_data[k] with out_val[k]=1 on the next cycle (latency 1, no bypass).
  - Dequeue: out_val[k] && out_rdy[k]. The head advances on the clock edge.
  - out_val[k] = (count!=0). out_data[k] = head entry, and is held stable while out_val && !out_rdy.
  - Enqueue and dequeue in the same cycle are allowed when not full; count is then unchanged.
  - When full, csrw_rdy=0 even if a dequeue happens in the same cycle. This keeps ready independent of out_rdy.
- csrw_rdy:
  - csrw_idx < p_num_out: rdy = !full[csrw_idx].
  - csrw_idx >= p_num_out: rdy = 1, data dropped, err set to 1 on the next edge (only if csrw_en).
  - With csrw_en=0, csrw_rdy is still driven but nothing happens.
- Input read, csrr_idx < p_num_in:
  - csrr_rdy = in_val[idx], csrr_data = in_data[idx].
  - in_rdy[idx] = csrr_en && in_val[idx]; all other in_rdy bits = 0.
  - The handshake is purely combinational and completes in the same cycle.
- Status read, csrr_idx == 4'hF:
  - csrr_rdy = 1.
  - csrr_data[p_num_in-1:0] = in_val.
  - csrr_data[16 +: p_num_out] = full flags.
  - All other bits = 0. No in_rdy asserted.
- Other csrr_idx values: csrr_rdy=1, csrr_data=0, err set to 1 on the next edge if csrr_en.
- When csrr_en=0, csrr_data=0.
- Simultaneous csrw and csrr in one cycle: the two are independent and both complete.
- The controller holds the W stage (trace_stall) while (csrw_en && !csrw_rdy) || (csrr_en && !csrr_rdy).
- err is only cleared by rst.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 1 cycle, then idle.
  - Response: out_val=0, in_rdy=0, err=0. Status read (idx F, in_val=3'b010) returns 32'h0000_0002 with csrr_rdy=1.
- Single write latency:
  - Stimulus: csrw idx=1 data=32'hDEAD_BEEF, out_rdy=0.
  - Response: csrw_rdy=1. Next cycle out_val=3'b010, out_data[1]=DEADBEEF, held for 3 stalled cycles.
  - Then out_rdy[1]=1 for 1 cycle: out_val[1]=0.
- Fill/full with p_depth=4:
  - Stimulus: write 1,2,3,4 to ch0 with out_rdy=0, then 5th write 5 while out_rdy[0]=1.
  - Response: csrw_rdy=0 on the 5th write in that cycle. The next cycle accepts 5.
  - Drained order: 1,2,3,4,5 (checks pointer wrap).
- Concurrent enq/deq:
  - Stimulus: ch2 holding 2 entries, enqueue 9 and dequeue in the same cycle.
  - Response: count stays 2, order preserved.
- Input stall:
  - Stimulus: csrr idx=0 with in_val=0 for 2 cycles, then in_val[0]=1, in_data=32'h1234.
  - Response: csrr_rdy=0 and in_rdy=0 for 2 cycles. Then csrr_rdy=1, csrr_data=1234, in_rdy=3'b001 for exactly that cycle.
- Out-of-range and mid-op reset:
  - Stimulus: csrw idx=7.
  - Response: csrw_rdy=1, no out_val change, err=1 next cycle.
  - Stimulus: rst with 3 entries queued.
  - Response: all out_val=0 and err=0 the next cycle.
